// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

  localparam int NUM_PORTS        = 2;
  localparam int DEFAULT_MEM_SIZE = 1024;
  localparam int MEM_BYTES        = DEFAULT_MEM_SIZE * 4;

  // Highest legal word-aligned byte address for a memory of the given depth.
  function automatic int unsigned last_word_addr(input int unsigned words);
    return words * 4 - 4;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; force_en pins the grant to force_id (lock owner).
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_id,
  output logic [1:0] grant,
  output logic       id
);

  always_comb begin
    grant = 2'b00;
    id    = 1'b0;
    if (force_en) begin
      // A locked owner that is idle leaves the memory idle; the other port waits.
      id              = force_id;
      grant[force_id] = valid[force_id];
    end else if (valid == 2'b11) begin
      id           = ~last;
      grant[~last] = 1'b1;
    end else if (valid[1]) begin
      id    = 1'b1;
      grant = 2'b10;
    end else if (valid[0]) begin
      id    = 1'b0;
      grant = 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with RMW lock, lock timeout and bounds check
// in front of a single-ported, combinationally read data memory.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_SIZE     = DEFAULT_MEM_SIZE,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_PORTS-1:0]                  req_valid,
  output logic [NUM_PORTS-1:0]                  req_ready,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS-1:0]                  req_we,
  input  logic [NUM_PORTS-1:0][3:0]             req_be,
  input  logic [NUM_PORTS-1:0]                  req_lock,
  output logic [NUM_PORTS-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  rsp_err,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  output logic                                  mem_we,
  output logic [3:0]                            mem_be,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(last_word_addr(MEM_SIZE));

  lock_state_e          state;
  logic                 owner;
  logic [CNT_W-1:0]     idle_cnt;
  logic                 last_grant;
  logic [1:0]           grant;
  logic                 g;
  logic                 fire;
  logic                 in_range;

  rr_arbiter2 u_rr (
    .valid    (req_valid),
    .last     (last_grant),
    .force_en (state == LOCKED),
    .force_id (owner),
    .grant    (grant),
    .id       (g)
  );

  // Request stage: grant, handshake and memory mux, no added latency
  assign req_ready = reset ? 2'b00 : grant;
  assign fire      = |(req_valid & req_ready);
  assign in_range  = (req_addr[g] <= MAX_ADDR);

  assign mem_addr  = req_addr[g];
  assign mem_wdata = req_wdata[g];
  assign mem_be    = req_be[g];
  assign mem_we    = fire & req_we[g] & in_range;

  // Response stage: one-cycle pulse to the winner with captured read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (fire) begin
      rsp_valid <= req_ready;
      rsp_rdata <= (req_we[g] || !in_range) ? '0 : mem_rdata;
      rsp_err   <= !in_range;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= UNLOCKED;
      owner      <= 1'b0;
      idle_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      if (fire) last_grant <= g;
      case (state)
        UNLOCKED: begin
          idle_cnt <= '0;
          if (fire && req_lock[g]) begin
            state <= LOCKED;
            owner <= g;
          end
        end
        LOCKED: begin
          // An owner request in the same cycle as the timeout takes precedence.
          if (fire) begin
            idle_cnt <= '0;
            if (!req_lock[g]) state <= UNLOCKED;
          end else if (!req_valid[owner]) begin
            if (idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
              state    <= UNLOCKED;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural memory attached.
module tb_dmem_arbiter;

  localparam int MEM_SIZE = 1024;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][3:0]  req_be;
  logic [31:0]      rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic             rsp_err, mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem [MEM_SIZE];

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE), .LOCK_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .req_be(req_be), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk)
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic set_port(input int p, input logic [31:0] addr, input logic we,
                          input logic [31:0] wd, input logic lock);
    req_valid[p] = 1'b1;
    req_addr[p]  = addr;
    req_we[p]    = we;
    req_wdata[p] = wd;
    req_be[p]    = 4'hF;
    req_lock[p]  = lock;
  endtask

  // Checks the handshake now, queues the expected response, compares it next cycle.
  task automatic step(input string tag, input logic [1:0] exp_rdy, input logic exp_we,
                      input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    #1;
    chk({tag, "_rdy"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, "_mwe"}, 32'(mem_we), 32'(exp_we));
    sbq.push_back('{vld: exp_rdy, rdata: exp_rdata, err: exp_err});
    @(posedge clk);
    @(negedge clk);
    e = sbq.pop_front();
    chk({tag, "_rvld"}, 32'(rsp_valid), 32'(e.vld));
    if (e.vld != 2'b00) begin
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_rerr"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  task automatic do_reset();
    idle_all();
    reset = 1'b1;
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    idle_all();
    for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 32'hA500_0000 | i;
    #0;
    mem[4] <= 32'hDEADBEEF;
    @(negedge clk);

    // Reset values, even with both ports requesting
    set_port(0, 32'h10, 1'b1, 32'h1, 1'b0);
    set_port(1, 32'h14, 1'b1, 32'h2, 1'b0);
    #1;
    chk("rst_rdy", 32'(req_ready), 32'h0);
    chk("rst_rvld", 32'(rsp_valid), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_rerr", 32'(rsp_err), 32'h0);
    chk("rst_mwe", 32'(mem_we), 32'h0);
    @(negedge clk);
    idle_all();
    reset = 1'b0;

    // Single read on port 0
    set_port(0, 32'h10, 1'b0, 32'h0, 1'b0);
    step("rd0", 2'b01, 1'b0, 32'hDEADBEEF, 1'b0);
    idle_all();

    // Contested round-robin straight after reset
    do_reset();
    set_port(0, 32'h10, 1'b0, 32'h0, 1'b0);
    set_port(1, 32'h14, 1'b0, 32'h0, 1'b0);
    step("rr0", 2'b01, 1'b0, 32'hDEADBEEF, 1'b0);
    step("rr1", 2'b10, 1'b0, 32'hA500_0005, 1'b0);
    step("rr2", 2'b01, 1'b0, 32'hDEADBEEF, 1'b0);
    step("rr3", 2'b10, 1'b0, 32'hA500_0005, 1'b0);
    idle_all();

    // Port 1 locked RMW holds off port 0 until its unlocking transfer
    set_port(1, 32'h20, 1'b1, 32'h1234_5678, 1'b1);
    step("lk_wr", 2'b10, 1'b1, 32'h0, 1'b0);
    set_port(0, 32'h10, 1'b0, 32'h0, 1'b0);
    set_port(1, 32'h20, 1'b0, 32'h0, 1'b1);
    step("lk_a", 2'b10, 1'b0, 32'h1234_5678, 1'b0);
    set_port(1, 32'h20, 1'b0, 32'h0, 1'b0);
    step("lk_b", 2'b10, 1'b0, 32'h1234_5678, 1'b0);
    step("lk_c", 2'b01, 1'b0, 32'hDEADBEEF, 1'b0);
    chk("lk_mem", mem[8], 32'h1234_5678);
    idle_all();

    // Lock timeout: owner idle 16 cycles, port 1 granted on the 17th
    set_port(0, 32'h10, 1'b0, 32'h0, 1'b1);
    step("to_lk", 2'b01, 1'b0, 32'hDEADBEEF, 1'b0);
    idle_all();
    set_port(1, 32'h14, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 16; i++) step("to_wait", 2'b00, 1'b0, 32'h0, 1'b0);
    step("to_grant", 2'b10, 1'b0, 32'hA500_0005, 1'b0);
    idle_all();

    // Bounds: first out-of-range write and read, last in-range read
    set_port(0, 32'(MEM_SIZE * 4), 1'b1, 32'h55, 1'b0);
    step("oor_wr", 2'b01, 1'b0, 32'h0, 1'b1);
    chk("oor_mem", mem[0], 32'hA500_0000);
    set_port(0, 32'(MEM_SIZE * 4), 1'b0, 32'h0, 1'b0);
    step("oor_rd", 2'b01, 1'b0, 32'h0, 1'b1);
    set_port(0, 32'(MEM_SIZE * 4 - 4), 1'b0, 32'h0, 1'b0);
    step("edge_rd", 2'b01, 1'b0, 32'hA500_03FF, 1'b0);
    idle_all();

    // Reset while locked with a response in flight
    set_port(1, 32'h30, 1'b1, 32'hCAFE_F00D, 1'b1);
    step("mr_lk", 2'b10, 1'b1, 32'h0, 1'b0);
    set_port(0, 32'h10, 1'b0, 32'h0, 1'b0);
    set_port(1, 32'h30, 1'b0, 32'h0, 1'b1);
    #1;
    chk("mr_rdy", 32'(req_ready), 32'h2);
    @(posedge clk);
    #2;
    chk("mr_pend", 32'(rsp_valid), 32'h2);
    reset = 1'b1;
    #1;
    chk("mr_rvld", 32'(rsp_valid), 32'h0);
    chk("mr_rdata", rsp_rdata, 32'h0);
    chk("mr_rerr", 32'(rsp_err), 32'h0);
    chk("mr_rdy0", 32'(req_ready), 32'h0);
    chk("mr_mwe", 32'(mem_we), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step("mr_post", 2'b01, 1'b0, 32'hDEADBEEF, 1'b0);
    idle_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
